// File: rtl/payment_collector.sv
// Coin-operated payment collector: credits coins toward a fixed price, releases
// the item, and pays change or refunds through a ready/valid change dispenser.
module payment_collector #(
  parameter int PRICE_CMT   = 65,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_valid_i,
  input  logic [1:0] coin_type_i,
  input  logic       cancel_i,
  input  logic       change_ready_i,
  output logic       change_valid_o,
  output logic [6:0] change_cmt_o,
  output logic       vend_o,
  output logic       coin_reject_o,
  output logic [6:0] balance_o,
  output logic       busy_o
);

  localparam logic [6:0]  PRICE   = 7'(PRICE_CMT);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, PAYOUT} state_t;

  state_t      state, state_nxt;
  logic [6:0]  bal_q, bal_nxt;
  logic [6:0]  chg_q, chg_nxt;
  logic [15:0] cnt_q, cnt_nxt;
  logic        rej_q;
  logic [6:0]  coin_val;
  logic [6:0]  bal_plus;

  function automatic logic [6:0] coin_value(input logic [1:0] kind);
    case (kind)
      2'b00:   return 7'd1;
      2'b01:   return 7'd5;
      2'b10:   return 7'd10;
      default: return 7'd25;
    endcase
  endfunction

  // Balance never exceeds PRICE-1+25 <= 124, so 7-bit addition cannot wrap.
  assign coin_val = coin_value(coin_type_i);
  assign bal_plus = bal_q + coin_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      bal_q <= '0;
      chg_q <= '0;
      cnt_q <= '0;
      rej_q <= 1'b0;
    end else begin
      state <= state_nxt;
      bal_q <= bal_nxt;
      chg_q <= chg_nxt;
      cnt_q <= cnt_nxt;
      rej_q <= coin_valid_i & ((state == VEND) | (state == PAYOUT));
    end
  end

  always_comb begin
    state_nxt = state;
    bal_nxt   = bal_q;
    chg_nxt   = chg_q;
    cnt_nxt   = cnt_q;
    case (state)
      IDLE: begin
        if (coin_valid_i) begin
          bal_nxt   = bal_plus;
          cnt_nxt   = '0;
          state_nxt = (bal_plus >= PRICE) ? VEND : COLLECT;
        end
      end
      COLLECT: begin
        // A coin that reaches the price beats a simultaneous cancel.
        if (coin_valid_i) begin
          bal_nxt = bal_plus;
          if (bal_plus >= PRICE) begin
            state_nxt = VEND;
          end else if (cancel_i) begin
            state_nxt = PAYOUT;
            chg_nxt   = bal_plus;
          end else begin
            cnt_nxt = '0;
          end
        end else if (cancel_i || (cnt_q == TO_LAST)) begin
          state_nxt = PAYOUT;
          chg_nxt   = bal_q;
        end else begin
          cnt_nxt = cnt_q + 16'd1;
        end
      end
      VEND: begin
        if (bal_q == PRICE) begin
          state_nxt = IDLE;
          bal_nxt   = '0;
          cnt_nxt   = '0;
        end else begin
          state_nxt = PAYOUT;
          chg_nxt   = bal_q - PRICE;
        end
      end
      PAYOUT: begin
        if (change_ready_i) begin
          state_nxt = IDLE;
          bal_nxt   = '0;
          cnt_nxt   = '0;
          chg_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // All outputs come from registered state, never straight from inputs.
  assign vend_o         = (state == VEND);
  assign busy_o         = (state == VEND) | (state == PAYOUT);
  assign change_valid_o = (state == PAYOUT);
  assign change_cmt_o   = (state == PAYOUT) ? chg_q : 7'd0;
  assign coin_reject_o  = rej_q;
  assign balance_o      = bal_q;

endmodule

// File: tb/tb_payment_collector.sv
// Bench for payment_collector: directed scenarios plus random coins/cancels,
// all outputs compared every cycle against a transaction-level model.
module tb_payment_collector;

  localparam int PRICE = 65;
  localparam int TO    = 4;

  localparam int PENNY = 0, NICKEL = 1, DIME = 2, QUARTER = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_valid_i = 1'b0;
  logic [1:0] coin_type_i = 2'b00;
  logic       cancel_i = 1'b0;
  logic       change_ready_i = 1'b0;
  logic       change_valid_o;
  logic [6:0] change_cmt_o;
  logic       vend_o;
  logic       coin_reject_o;
  logic [6:0] balance_o;
  logic       busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  payment_collector #(.PRICE_CMT(PRICE), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .coin_valid_i(coin_valid_i), .coin_type_i(coin_type_i),
    .cancel_i(cancel_i), .change_ready_i(change_ready_i),
    .change_valid_o(change_valid_o), .change_cmt_o(change_cmt_o),
    .vend_o(vend_o), .coin_reject_o(coin_reject_o),
    .balance_o(balance_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Transaction model: what the customer has paid, what is owed back, and
  // which phase of the purchase the machine is in.
  typedef enum {M_IDLE, M_COLLECT, M_VEND, M_PAYOUT} phase_t;
  phase_t m_phase;
  int     m_credit, m_owed, m_quiet;
  bit     m_reject;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int cents(input int kind);
    int tbl[4] = '{1, 5, 10, 25};
    return tbl[kind];
  endfunction

  task automatic model_reset();
    m_phase = M_IDLE; m_credit = 0; m_owed = 0; m_quiet = 0; m_reject = 0;
  endtask

  task automatic model_edge(input bit coin, input int kind, input bit cancel, input bit ready);
    m_reject = coin && (m_phase == M_VEND || m_phase == M_PAYOUT);
    case (m_phase)
      M_IDLE, M_COLLECT: begin
        if (coin) begin
          m_credit += cents(kind);
          m_quiet = 0;
          if (m_credit >= PRICE) m_phase = M_VEND;
          else if (m_phase == M_COLLECT && cancel) begin m_owed = m_credit; m_phase = M_PAYOUT; end
          else m_phase = M_COLLECT;
        end else if (m_phase == M_COLLECT) begin
          if (cancel || m_quiet + 1 >= TO) begin m_owed = m_credit; m_phase = M_PAYOUT; end
          else m_quiet++;
        end
      end
      M_VEND: begin
        m_owed = m_credit - PRICE;
        if (m_owed == 0) begin m_credit = 0; m_phase = M_IDLE; end
        else m_phase = M_PAYOUT;
      end
      M_PAYOUT: if (ready) begin m_credit = 0; m_owed = 0; m_quiet = 0; m_phase = M_IDLE; end
    endcase
  endtask

  task automatic compare_all();
    check_eq("vend",     int'(vend_o),         int'(m_phase == M_VEND));
    check_eq("busy",     int'(busy_o),         int'(m_phase == M_VEND || m_phase == M_PAYOUT));
    check_eq("chg_vld",  int'(change_valid_o), int'(m_phase == M_PAYOUT));
    check_eq("chg_cmt",  int'(change_cmt_o),   (m_phase == M_PAYOUT) ? m_owed : 0);
    check_eq("balance",  int'(balance_o),      m_credit);
    check_eq("reject",   int'(coin_reject_o),  int'(m_reject));
  endtask

  // Called near the falling edge: drive inputs, take a rising edge, update
  // the model, then compare at the next falling edge.
  task automatic step(input bit coin, input int kind, input bit cancel, input bit ready);
    coin_valid_i   = coin;
    coin_type_i    = 2'(kind);
    cancel_i       = cancel;
    change_ready_i = ready;
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(coin, kind, cancel, ready);
    @(negedge clk);
    compare_all();
  endtask

  task automatic quiet(input int n, input bit ready);
    for (int i = 0; i < n; i++) step(0, 0, 0, ready);
  endtask

  initial begin
    model_reset();
    @(negedge clk);

    // Coins under reset are not credited.
    rst = 1'b1;
    step(1, QUARTER, 0, 0);
    step(1, DIME, 1, 1);
    check_eq("rst_bal", int'(balance_o), 0);
    check_eq("rst_busy", int'(busy_o), 0);
    rst = 1'b0;

    // Three quarters: 25,50,75 then change 10 held until ready.
    step(1, QUARTER, 0, 0);  check_eq("q1_bal", int'(balance_o), 25);
    step(1, QUARTER, 0, 0);  check_eq("q2_bal", int'(balance_o), 50);
    step(1, QUARTER, 0, 0);  check_eq("q3_vend", int'(vend_o), 1);
    step(0, 0, 0, 0);        check_eq("q3_cmt", int'(change_cmt_o), 10);
    quiet(2, 0);             check_eq("q3_hold", int'(change_cmt_o), 10);
    step(0, 0, 0, 1);        check_eq("q3_idle", int'(balance_o), 0);

    // Exact payment: no change cycle.
    step(1, QUARTER, 0, 0);
    step(1, QUARTER, 0, 0);
    step(1, DIME, 0, 0);
    step(1, NICKEL, 0, 0);   check_eq("exact_vend", int'(vend_o), 1);
    step(0, 0, 0, 0);        check_eq("exact_nochg", int'(change_valid_o), 0);

    // Cancel with a penny on the same cycle refunds 16; coin in payout rejected.
    step(1, DIME, 0, 0);
    step(1, NICKEL, 0, 0);
    step(1, PENNY, 1, 0);    check_eq("cancel_cmt", int'(change_cmt_o), 16);
    step(1, QUARTER, 0, 0);  check_eq("rej_pulse", int'(coin_reject_o), 1);
    check_eq("rej_bal", int'(balance_o), 16);
    step(0, 0, 0, 1);        check_eq("rej_once", int'(coin_reject_o), 0);

    // Coin reaching price together with cancel vends.
    step(1, QUARTER, 0, 0);
    step(1, QUARTER, 0, 0);
    step(1, QUARTER, 1, 1);  check_eq("vend_wins", int'(vend_o), 1);
    quiet(2, 1);

    // Timeout refund of a single penny, then async reset inside payout.
    step(1, PENNY, 0, 0);
    quiet(3, 0);             check_eq("to_early", int'(change_valid_o), 0);
    step(0, 0, 0, 0);        check_eq("to_cmt", int'(change_cmt_o), 1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_vld", int'(change_valid_o), 0);
    check_eq("arst_busy", int'(busy_o), 0);
    check_eq("arst_bal", int'(balance_o), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1, DIME, 0, 0);     check_eq("first_coin", int'(balance_o), 10);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit c, cn, rd;
      c  = ($urandom_range(0, 2) == 0);
      cn = ($urandom_range(0, 7) == 0);
      rd = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 199) == 0);
      step(c, int'($urandom_range(0, 3)), cn, rd);
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
